// File: rtl/mtx_pkg.sv
// Shared types and constants for the mtx_burst_gate burst framer.
// The optional gain stage (MTX_BURST_GAIN_EN) uses GAIN_FRAC from here.
package mtx_pkg;
   typedef enum logic [1:0] {IDLE, ARM, TX, GUARD} mtx_state_t;

   localparam int IQ_W      = 32;
   localparam int GAIN_FRAC = 14;

   function automatic int iq_width(input int sin_cos_width);
      return 2 * sin_cos_width;
   endfunction
endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream skid buffer: registered output stage plus one skid slot.
// in_ready is driven straight from a flop so it never depends on out_ready.
module axis_skid_buf #(
   parameter int DATA_W = 33
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              srst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);
   logic              r_out_valid;
   logic              r_skid_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [DATA_W-1:0] r_skid_data;
   logic              w_push;
   logic              w_load;

   assign w_push = in_valid && !r_skid_valid;
   assign w_load = !r_out_valid || out_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_out_data   <= '0;
         r_skid_data  <= '0;
      end else if (srst) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_out_data   <= '0;
         r_skid_data  <= '0;
      end else if (w_load) begin
         // A full skid slot always drains first, so ordering is preserved.
         if (r_skid_valid) begin
            r_out_data   <= r_skid_data;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_push) begin
            r_out_data  <= in_data;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_push) begin
         r_skid_data  <= in_data;
         r_skid_valid <= 1'b1;
      end
   end

   assign in_ready  = !r_skid_valid;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
endmodule

// File: rtl/mtx_burst_gate.sv
// Cuts symbol-aligned TX bursts with zero guards out of a free-running IQ stream.
// Optional MTX_BURST_GAIN_EN adds a gain port and one saturating gain pipeline stage.
module mtx_burst_gate
   import mtx_pkg::*;
#(
   parameter int SIN_COS_WIDTH = IQ_W / 2,
   parameter int CNT_WIDTH     = 16,
   parameter int SYMB_LEN      = 8192,
   parameter int NSYMB         = 8,
   parameter int GUARD_LEN     = 256
`ifdef MTX_BURST_GAIN_EN
   , parameter int GAIN_WIDTH  = 16
`endif
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         srst,
   input  logic                         enable,
   input  logic                         trigger,
   input  logic                         in_tvalid,
   output logic                         in_tready,
   input  logic                         in_tlast,
   input  logic [SIN_COS_WIDTH-1:0]     in_i,
   input  logic [SIN_COS_WIDTH-1:0]     in_q,
`ifdef MTX_BURST_GAIN_EN
   input  logic [GAIN_WIDTH-1:0]        gain,
`endif
   output logic                         out_tvalid,
   input  logic                         out_tready,
   output logic                         out_tlast,
   output logic [2*SIN_COS_WIDTH-1:0]   out_tdata,
   output logic                         busy,
   output logic                         trig_overrun,
   output logic [CNT_WIDTH-1:0]         burst_count
);
   localparam int W_IQ = iq_width(SIN_COS_WIDTH);
   localparam logic [CNT_WIDTH-1:0] SAMP_LAST  = CNT_WIDTH'(SYMB_LEN - 1);
   localparam logic [CNT_WIDTH-1:0] SYMB_LAST  = CNT_WIDTH'(NSYMB - 1);
   localparam logic [CNT_WIDTH-1:0] GUARD_LAST = CNT_WIDTH'((GUARD_LEN > 0) ? GUARD_LEN - 1 : 0);

   mtx_state_t           r_state;
   mtx_state_t           w_state_next;
   logic [CNT_WIDTH-1:0] r_samp_cnt;
   logic [CNT_WIDTH-1:0] r_symb_cnt;
   logic [CNT_WIDTH-1:0] r_guard_cnt;
   logic [CNT_WIDTH-1:0] r_burst_count;
   logic                 r_overrun;
   logic                 w_in_acc;
   logic                 w_symb_end;
   logic                 w_burst_end;
   logic                 w_guard_push;
   logic                 w_src_valid;
   logic                 w_src_ready;
   logic                 w_src_last;
   logic [W_IQ-1:0]      w_src_data;
   logic                 w_skid_valid;
   logic                 w_skid_last;
   logic [W_IQ-1:0]      w_skid_data;
   logic                 w_buf_ready;
   logic [W_IQ:0]        w_buf_out;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   r_state <= IDLE;
      else if (srst) r_state <= IDLE;
      else           r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_tready    = 1'b1;
      w_src_valid  = 1'b0;
      w_src_last   = 1'b0;
      w_src_data   = '0;
      w_in_acc     = 1'b0;
      w_symb_end   = 1'b0;
      w_burst_end  = 1'b0;
      w_guard_push = 1'b0;
      case (r_state)
         IDLE: begin
            if (trigger && enable) w_state_next = ARM;
         end
         ARM: begin
            if (!enable)                     w_state_next = IDLE;
            else if (in_tvalid && in_tlast)  w_state_next = TX;
         end
         TX: begin
            in_tready   = w_src_ready;
            w_src_valid = in_tvalid;
            w_src_data  = {in_q, in_i};
            w_in_acc    = in_tvalid && w_src_ready;
            w_symb_end  = w_in_acc && (r_samp_cnt == SAMP_LAST);
            w_burst_end = w_symb_end && ((r_symb_cnt == SYMB_LAST) || !enable);
            w_src_last  = w_burst_end;
            if (w_burst_end)                      w_state_next = IDLE;
            else if (w_symb_end && GUARD_LEN > 0) w_state_next = GUARD;
         end
         GUARD: begin
            // Upstream stalls while the gate injects its own zero beats.
            in_tready    = 1'b0;
            w_src_valid  = 1'b1;
            w_guard_push = w_src_ready;
            if (w_guard_push && (r_guard_cnt == GUARD_LAST)) w_state_next = TX;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_samp_cnt    <= '0;
         r_symb_cnt    <= '0;
         r_guard_cnt   <= '0;
         r_burst_count <= '0;
         r_overrun     <= 1'b0;
      end else if (srst) begin
         r_samp_cnt    <= '0;
         r_symb_cnt    <= '0;
         r_guard_cnt   <= '0;
         r_burst_count <= '0;
         r_overrun     <= 1'b0;
      end else begin
         if (w_symb_end) begin
            r_samp_cnt <= '0;
            r_symb_cnt <= w_burst_end ? '0 : r_symb_cnt + 1'b1;
         end else if (w_in_acc) begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
         end
         if (w_guard_push) r_guard_cnt <= (r_guard_cnt == GUARD_LAST) ? '0 : r_guard_cnt + 1'b1;
         if (w_burst_end)  r_burst_count <= r_burst_count + 1'b1;
         if (trigger && (r_state != IDLE)) r_overrun <= 1'b1;
      end
   end

`ifdef MTX_BURST_GAIN_EN
   localparam int PW = SIN_COS_WIDTH + GAIN_WIDTH + 1;
   localparam logic signed [PW-1:0] ROUND_HALF = PW'(1) <<< (GAIN_FRAC - 1);
   localparam logic signed [PW-1:0] SAT_MAX    = PW'((1 << (SIN_COS_WIDTH - 1)) - 1);
   localparam logic signed [PW-1:0] SAT_MIN    = -SAT_MAX - 1;

   function automatic logic [SIN_COS_WIDTH-1:0] apply_gain(
      input logic [SIN_COS_WIDTH-1:0] x, input logic [GAIN_WIDTH-1:0] g);
      logic signed [PW-1:0] prod;
      prod = ($signed(x) * $signed({1'b0, g}) + ROUND_HALF) >>> GAIN_FRAC;
      if (prod > SAT_MAX) return SAT_MAX[SIN_COS_WIDTH-1:0];
      if (prod < SAT_MIN) return SAT_MIN[SIN_COS_WIDTH-1:0];
      return prod[SIN_COS_WIDTH-1:0];
   endfunction

   logic            r_pipe_valid;
   logic            r_pipe_last;
   logic [W_IQ-1:0] r_pipe_data;

   assign w_src_ready = !r_pipe_valid || w_buf_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pipe_valid <= 1'b0;
         r_pipe_last  <= 1'b0;
         r_pipe_data  <= '0;
      end else if (srst) begin
         r_pipe_valid <= 1'b0;
         r_pipe_last  <= 1'b0;
         r_pipe_data  <= '0;
      end else if (w_src_ready) begin
         r_pipe_valid <= w_src_valid;
         r_pipe_last  <= w_src_last;
         r_pipe_data  <= {apply_gain(w_src_data[W_IQ-1:SIN_COS_WIDTH], gain),
                          apply_gain(w_src_data[SIN_COS_WIDTH-1:0], gain)};
      end
   end

   assign w_skid_valid = r_pipe_valid;
   assign w_skid_last  = r_pipe_last;
   assign w_skid_data  = r_pipe_data;
`else
   assign w_src_ready  = w_buf_ready;
   assign w_skid_valid = w_src_valid;
   assign w_skid_last  = w_src_last;
   assign w_skid_data  = w_src_data;
`endif

   axis_skid_buf #(.DATA_W(W_IQ + 1)) u_skid (
      .clk       (clk),
      .resetn    (resetn),
      .srst      (srst),
      .in_valid  (w_skid_valid),
      .in_ready  (w_buf_ready),
      .in_data   ({w_skid_last, w_skid_data}),
      .out_valid (out_tvalid),
      .out_ready (out_tready),
      .out_data  (w_buf_out)
   );

   assign out_tlast    = w_buf_out[W_IQ];
   assign out_tdata    = w_buf_out[W_IQ-1:0];
   assign busy         = (r_state != IDLE);
   assign trig_overrun = r_overrun;
   assign burst_count  = r_burst_count;
endmodule

// File: tb/tb_mtx_burst_gate.sv
// Scoreboard bench for mtx_burst_gate with SYMB_LEN=4, NSYMB=2, GUARD_LEN=2.
// Define MTX_BURST_GAIN_EN to also exercise the gain stage.
module tb_mtx_burst_gate;
   import mtx_pkg::*;

   logic            clk = 1'b0;
   logic            resetn, srst, enable, trigger;
   logic            in_tvalid, in_tready, in_tlast;
   logic [15:0]     in_i, in_q;
   logic            out_tvalid, out_tready, out_tlast;
   logic [IQ_W-1:0] out_tdata;
   logic            busy, trig_overrun;
   logic [15:0]     burst_count;
`ifdef MTX_BURST_GAIN_EN
   logic [15:0]     gain;
`endif

   int          checks = 0;
   int          failures = 0;
   int          popped = 0;
   logic [32:0] exp_q[$];
   logic [15:0] n;
   bit          bp_mode = 1'b0;
   bit          force_on = 1'b0;
   logic [15:0] force_i = '0;
   logic [15:0] force_exp = '0;

   always #5 clk = ~clk;

   mtx_burst_gate #(
      .SIN_COS_WIDTH(16), .CNT_WIDTH(16), .SYMB_LEN(4), .NSYMB(2), .GUARD_LEN(2)
   ) dut (
      .clk(clk), .resetn(resetn), .srst(srst), .enable(enable), .trigger(trigger),
      .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
      .in_i(in_i), .in_q(in_q),
`ifdef MTX_BURST_GAIN_EN
      .gain(gain),
`endif
      .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
      .out_tdata(out_tdata), .busy(busy), .trig_overrun(trig_overrun),
      .burst_count(burst_count)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_gain(input logic [15:0] x, input logic [15:0] g);
      longint p;
      p = (longint'($signed(x)) * longint'(g) + (longint'(1) <<< (GAIN_FRAC - 1))) >>> GAIN_FRAC;
      if (p > 32767) p = 32767;
      else if (p < -32768) p = -32768;
      return p[15:0];
   endfunction

   function automatic logic [15:0] exp_sample(input logic [15:0] v, input bit is_i);
      if (is_i && force_on) return force_exp;
`ifdef MTX_BURST_GAIN_EN
      return model_gain(v, gain);
`else
      return v;
`endif
   endfunction

   // Free-running ramp source and output monitor, all on the falling edge.
   initial begin
      logic        fire_in;
      logic        stall_prev;
      logic [32:0] stall_word;
      logic [32:0] e;
      n = '0; fire_in = 1'b0; stall_prev = 1'b0; stall_word = '0;
      in_tvalid = 1'b1; out_tready = 1'b1;
      forever begin
         @(negedge clk);
         if (fire_in) n = n + 16'd1;
         in_i     = force_on ? force_i : n;
         in_q     = n;
         in_tlast = (n[1:0] == 2'b11);
         out_tready = bp_mode ? !out_tready : 1'b1;
         if (stall_prev)
            check_val("hold", {31'd0, out_tvalid, out_tlast, out_tdata}, {31'd0, 1'b1, stall_word});
         fire_in    = in_tvalid && in_tready;
         stall_prev = out_tvalid && !out_tready;
         stall_word = {out_tlast, out_tdata};
         if (out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
               check_val("extra_beat", {63'd0, out_tvalid}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               popped++;
               $display("beat %0d last=%0b q=%h i=%h", popped, out_tlast, out_tdata[31:16], out_tdata[15:0]);
               check_val("beat", {31'd0, out_tlast, out_tdata}, {31'd0, e});
            end
         end
      end
   end

   task automatic fire_trigger(input bit early);
      logic [15:0] m, v;
      @(negedge clk); #1;
      m = n + 16'd1;
      while (m[1:0] != 2'b11) m = m + 16'd1;
      for (int k = 0; k < 8; k++) begin
         v = m + 16'd1 + 16'(k);
         if (early && k == 4) break;
         if (k == 4) begin
            exp_q.push_back(33'd0);
            exp_q.push_back(33'd0);
         end
         exp_q.push_back({(k == 7) || (early && k == 3), exp_sample(v, 1'b0), exp_sample(v, 1'b1)});
      end
      trigger = 1'b1;
      @(negedge clk); #1;
      trigger = 1'b0;
   endtask

   task automatic pulse_trigger();
      trigger = 1'b1;
      @(negedge clk); #1;
      trigger = 1'b0;
   endtask

   task automatic wait_popped(input int target);
      int cyc = 0;
      while (popped < target && cyc < 200) begin
         @(negedge clk); #1;
         cyc++;
      end
      if (popped < target) check_val("pop_timeout", 64'(popped), 64'(target));
   endtask

   task automatic wait_idle(input string tag);
      int cyc = 0;
      while ((exp_q.size() != 0 || busy || out_tvalid) && cyc < 300) begin
         @(negedge clk); #1;
         cyc++;
      end
      check_val({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
      check_val({tag, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      resetn = 1'b0; srst = 1'b0; enable = 1'b1; trigger = 1'b0;
`ifdef MTX_BURST_GAIN_EN
      gain = 16'h4000;
`endif
      repeat (3) @(negedge clk); #1;
      check_val("rst_tvalid", {63'd0, out_tvalid}, 64'd0);
      check_val("rst_tlast", {63'd0, out_tlast}, 64'd0);
      check_val("rst_tdata", 64'(out_tdata), 64'd0);
      check_val("rst_busy", {63'd0, busy}, 64'd0);
      check_val("rst_count", 64'(burst_count), 64'd0);
      check_val("rst_overrun", {63'd0, trig_overrun}, 64'd0);
      resetn = 1'b1;
      repeat (5) @(negedge clk); #1;

      fire_trigger(1'b0);
      wait_idle("burst");
      check_val("burst_count1", 64'(burst_count), 64'd1);
      check_val("burst_overrun", {63'd0, trig_overrun}, 64'd0);

      bp_mode = 1'b1;
      fire_trigger(1'b0);
      wait_idle("bp");
      bp_mode = 1'b0;
      check_val("bp_count", 64'(burst_count), 64'd2);
      repeat (3) @(negedge clk); #1;

      base = popped;
      fire_trigger(1'b0);
      wait_popped(base + 4);
      pulse_trigger();
      wait_idle("ovr");
      repeat (20) @(negedge clk); #1;
      check_val("ovr_flag", {63'd0, trig_overrun}, 64'd1);
      check_val("ovr_count", 64'(burst_count), 64'd3);
      check_val("ovr_single", 64'(popped - base), 64'd10);

      srst = 1'b1;
      @(negedge clk); #1;
      srst = 1'b0;
      check_val("srst_overrun", {63'd0, trig_overrun}, 64'd0);
      check_val("srst_count", 64'(burst_count), 64'd0);
      check_val("srst_busy", {63'd0, busy}, 64'd0);
      check_val("srst_tvalid", {63'd0, out_tvalid}, 64'd0);

      base = popped;
      fire_trigger(1'b1);
      wait_popped(base + 1);
      enable = 1'b0;
      wait_idle("early");
      enable = 1'b1;
      check_val("early_beats", 64'(popped - base), 64'd4);
      check_val("early_count", 64'(burst_count), 64'd1);

      base = popped;
      fire_trigger(1'b0);
      wait_popped(base + 2);
      resetn = 1'b0;
      #1;
      check_val("abort_tvalid", {63'd0, out_tvalid}, 64'd0);
      check_val("abort_busy", {63'd0, busy}, 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk); #1;
      resetn = 1'b1;
      check_val("abort_count", 64'(burst_count), 64'd0);
      repeat (3) @(negedge clk); #1;
      fire_trigger(1'b0);
      wait_idle("after_abort");
      check_val("after_abort_count", 64'(burst_count), 64'd1);

`ifdef MTX_BURST_GAIN_EN
      gain = 16'h2000; force_i = 16'd1000; force_exp = 16'd500; force_on = 1'b1;
      repeat (2) @(negedge clk); #1;
      fire_trigger(1'b0);
      wait_idle("gain_half");
      gain = 16'h8000; force_i = 16'h7FFF; force_exp = 16'h7FFF;
      repeat (2) @(negedge clk); #1;
      fire_trigger(1'b0);
      wait_idle("gain_sat");
      force_on = 1'b0;
      check_val("gain_count", 64'(burst_count), 64'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mtx_burst_gate.md
Name: mtx_burst_gate

Overview:
- Downstream consumer of the multi-tone IQ generator.
- Takes its free-running AXI-stream IQ samples (itx/qtx, tlast at symbol end) and emits symbol-aligned transmit bursts toward the radio TX path.
- Each burst is NSYMB symbols of SYMB_LEN samples, with GUARD_LEN zero samples between symbols.
- Bursts start on trigger, align to the generator's symbol boundary, and are buffered by a skid stage so backpressure never corrupts data.

Parameters:
SIN_COS_WIDTH, 16, width of each I and Q sample
CNT_WIDTH, 16, width of the sample, guard and symbol counters
SYMB_LEN, 8192, samples per symbol (1..2^CNT_WIDTH-1)
NSYMB, 8, symbols per burst (1..2^CNT_WIDTH-1)
GUARD_LEN, 256, zero samples inserted between symbols; 0 means no guard
GAIN_WIDTH, 16, gain word width (used only with the optional feature)

Ports:
clk  in  1  single clock
resetn  in  1  asynchronous active-low reset
srst  in  1  synchronous clear, same effect as reset
enable  in  1  burst permission
trigger  in  1  one-cycle pulse requesting a burst
in_tvalid  in  1  IQ input valid
in_tready  out  1  IQ input ready
in_tlast  in  1  last sample of an upstream symbol
in_i  in  SIN_COS_WIDTH  I sample
in_q  in  SIN_COS_WIDTH  Q sample
out_tvalid  out  1  output valid
out_tready  in  1  output ready
out_tlast  out  1  last beat of burst
out_tdata  out  2*SIN_COS_WIDTH  {Q,I}
busy  out  1  state is not IDLE
trig_overrun  out  1  sticky: trigger arrived while busy
burst_count  out  CNT_WIDTH  completed bursts, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (resetn low, asynchronous, or srst high at clk edge):
  - state=IDLE; all counters 0
  - out_tvalid=0, out_tlast=0, out_tdata=0
  - busy=0, trig_overrun=0, burst_count=0
  - skid buffer emptied
- Reset mid-burst aborts the burst; no tlast is emitted.
- FSM states: IDLE, ARM, TX, GUARD.
- IDLE:
  - in_tready=1; input beats are discarded so the generator keeps running.
  - trigger && enable -> ARM.
- ARM:
  - in_tready=1; discard beats.
  - Accepted beat with in_tlast=1 -> TX next cycle, so the first transmitted sample is the first sample of an upstream symbol.
  - enable low in ARM -> IDLE.
- TX:
  - Accepted input beats are forwarded to the skid buffer.
  - samp_cnt increments per accepted beat.
  - When samp_cnt reaches SYMB_LEN-1 on an accepted beat, the symbol ends and symb_cnt increments:
    - if symb_cnt==NSYMB-1 or enable==0: that beat carries out_tlast=1, burst_count++, -> IDLE.
    - else if GUARD_LEN>0: -> GUARD.
    - else: stay in TX.
  - in_tlast is not used for counting in TX.
- GUARD:
  - in_tready=0; generator stalls.
  - Emits GUARD_LEN beats of out_tdata=0 with out_tlast=0, counted on accepted output beats, then -> TX.
- Handshake:
  - A beat transfers when valid && ready.
  - out_tdata and out_tlast are held stable while out_tvalid && !out_tready.
  - in_tready in TX is a registered output of the 2-entry skid buffer (ready while at most 1 entry is occupied).
  - Latency from input accept to out_tvalid: 1 cycle.
- trigger while busy is ignored and sets trig_overrun. The flag clears only on reset/srst.
- trigger and the burst's final tlast in the same cycle: the trigger is ignored and trig_overrun is set.
- Counters compare with ==; no wrap occurs inside a burst.

Optional Feature:
- Macro: MTX_BURST_GAIN_EN.
- Defined:
  - Adds input port gain [GAIN_WIDTH-1:0], unsigned Q2.14.
  - I and Q are each multiplied by gain, rounded half-up, right-shifted 14, and saturated to signed SIN_COS_WIDTH.
  - Adds one pipeline register; latency becomes 2 cycles.
  - Guard zeros remain 0.
- Undefined: no gain port; samples pass unmodified; latency 1.

Decomposition:
- Package mtx_pkg:
  - FSM state enum (IDLE/ARM/TX/GUARD)
  - IQ_W = 2*SIN_COS_WIDTH
  - gain fractional-bit constant (14)
- Sub-module axis_skid_buf: 2-entry, parameterised data width, tlast carried as a data bit.
- FSM, counters and the gain stage live in the top.

Test Plan (SYMB_LEN=4, NSYMB=2, GUARD_LEN=2):
- Reset: pulse resetn low -> out_tvalid=0, busy=0, burst_count=0, trig_overrun=0. Pulse srst -> same state.
- Burst: input ramp I=Q=n with in_tlast every 4th beat, trigger, out_tready=1 -> 10 beats: 4 samples starting at a symbol start, 0, 0, next 4 samples; tlast only on beat 10; burst_count=1; busy=0.
- Backpressure: same stimulus with out_tready toggling 1010... -> identical 10-beat sequence; no loss or duplication; data held stable while stalled.
- Overrun: second trigger during GUARD -> ignored; trig_overrun=1; exactly one 10-beat burst.
- Early stop: enable drops during symbol 1 -> burst ends after 4 beats with tlast on beat 4; burst_count=1.
- Abort: resetn low mid-TX -> out_tvalid=0 immediately; next trigger yields a full correct burst.
- With MTX_BURST_GAIN_EN, gain=0x2000 and I=1000 -> out I=500. With gain=0x8000 and I=0x7FFF -> out I=0x7FFF (saturated).
